// File: rtl/rc4_key_search_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc4_search_pkg
// Description : Shared types and constants for the RC4 key-search sequencer.
//               Holds the sequencer state enum, the phase index constants
//               and the phase one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rc4_search_pkg;

  // Number of external phase engines run per key.
  localparam int NUM_PHASES = 4;

  // Phase indices; also the value driven on phase_sel.
  localparam logic [1:0] PH_SETUP    = 2'd0;
  localparam logic [1:0] PH_SCRAMBLE = 2'd1;
  localparam logic [1:0] PH_DECODE   = 2'd2;
  localparam logic [1:0] PH_CHECK    = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    START_PH = 3'd2,
    WAIT_PH  = 3'd3,
    EVAL     = 3'd4,
    NEXT     = 3'd5,
    DONE     = 3'd6
  } state_t;

  // One-hot phase_start pattern for a phase index.
  function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [1:0] idx);
    logic [NUM_PHASES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_key_search_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_search_ctrl_if
// Description : Phase-engine handshake between the key-search sequencer
//               (master) and the setup/scramble/decode/check engines (slave).
//   phase_start  : one-hot one-cycle start pulse, master -> engines
//   phase_finish : one-hot finish pulse, engines -> master
//   phase_sel    : active phase index, steers the RAM port muxes
//   valid        : checker verdict, meaningful with phase_finish[3]
// Revision    : 1.0 - initial release
// ============================================================================
interface rc4_key_search_ctrl_if;
  import rc4_search_pkg::*;

  logic [NUM_PHASES-1:0] phase_start;
  logic [NUM_PHASES-1:0] phase_finish;
  logic [1:0]            phase_sel;
  logic                  valid;

  modport master (
    output phase_start,
    output phase_sel,
    input  phase_finish,
    input  valid
  );

  modport slave (
    input  phase_start,
    input  phase_sel,
    output phase_finish,
    output valid
  );

endinterface
`default_nettype wire

// File: rtl/rc4_key_search_ctrl_stepper.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_stepper
// Description : Key register and tried-key counter for the key search.
//               All range arithmetic is done at KEY_W+1 bits so a key near
//               the top of the KEY_W space never wraps back into range.
// Ports       :
//   clock, reset_n : clock and synchronous active-low reset
//   load           : key <= MIN_KEY+OFFSET, keys_tried <= 0
//   step           : key <= key+STRIDE
//   count          : keys_tried <= keys_tried+1
//   first_oob      : first key of this instance lies beyond MAX_KEY
//   last_key       : key+STRIDE lies beyond MAX_KEY
//   key            : current key
//   keys_tried     : number of keys fully evaluated
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_key_stepper #(
  parameter int unsigned       KEY_W   = 24,
  parameter logic [KEY_W-1:0]  MIN_KEY = '0,
  parameter logic [KEY_W-1:0]  MAX_KEY = KEY_W'(24'h3FFFFF),
  parameter logic [KEY_W-1:0]  OFFSET  = '0,
  parameter logic [KEY_W-1:0]  STRIDE  = KEY_W'(1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             count,
  output logic             first_oob,
  output logic             last_key,
  output logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] keys_tried
);

  localparam logic [KEY_W:0]   C_FIRST_EXT = {1'b0, MIN_KEY} + {1'b0, OFFSET};
  localparam logic [KEY_W-1:0] C_FIRST_KEY = C_FIRST_EXT[KEY_W-1:0];
  localparam logic [KEY_W:0]   C_MAX_EXT   = {1'b0, MAX_KEY};

  logic [KEY_W-1:0] r_key;
  logic [KEY_W-1:0] r_tried;
  logic [KEY_W:0]   w_next_ext;

  assign w_next_ext = {1'b0, r_key} + {1'b0, STRIDE};
  assign first_oob  = (C_FIRST_EXT > C_MAX_EXT);
  assign last_key   = (w_next_ext > C_MAX_EXT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_key   <= C_FIRST_KEY;
      r_tried <= '0;
    end else if (load) begin
      r_key   <= C_FIRST_KEY;
      r_tried <= '0;
    end else begin
      if (step) begin
        r_key <= w_next_ext[KEY_W-1:0];
      end
      if (count) begin
        r_tried <= r_tried + KEY_W'(1);
      end
    end
  end

  assign key        = r_key;
  assign keys_tried = r_tried;

endmodule
`default_nettype wire

// File: rtl/rc4_key_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_search_ctrl
// Description : Brute-force RC4 key-search sequencer. Walks keys from
//               MIN_KEY+OFFSET in steps of STRIDE up to MAX_KEY, running the
//               setup, scramble, decode and check engines in order for each
//               key, and reports found / not_found / aborted.
//               Optional macro RC4_KEY_RESUME_EN adds a resume input that
//               continues the search past a found key.
// Ports       :
//   clock, reset_n : clock and synchronous active-low reset
//   start          : one-cycle pulse, begins a search from IDLE or DONE
//   halt           : level abort request
//   resume         : (RC4_KEY_RESUME_EN only) continue after a found key
//   eng            : phase-engine handshake (master side)
//   busy           : search in progress
//   found          : sticky, key is the winning key
//   not_found      : sticky, range exhausted
//   aborted        : sticky, search halted
//   key            : key under test or final key
//   keys_tried     : number of keys fully evaluated
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_key_search_ctrl
  import rc4_search_pkg::*;
#(
  parameter int unsigned       KEY_W   = 24,
  parameter logic [KEY_W-1:0]  MIN_KEY = '0,
  parameter logic [KEY_W-1:0]  MAX_KEY = KEY_W'(24'h3FFFFF),
  parameter logic [KEY_W-1:0]  OFFSET  = '0,
  parameter logic [KEY_W-1:0]  STRIDE  = KEY_W'(1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   halt,
`ifdef RC4_KEY_RESUME_EN
  input  logic                   resume,
`endif
  rc4_key_search_ctrl_if.master  eng,
  output logic                   busy,
  output logic                   found,
  output logic                   not_found,
  output logic                   aborted,
  output logic [KEY_W-1:0]       key,
  output logic [KEY_W-1:0]       keys_tried
);

  state_t                r_state;
  state_t                w_state_n;
  logic [1:0]            r_phase_sel;
  logic [1:0]            w_phase_sel_n;
  logic                  r_found;
  logic                  w_found_n;
  logic                  r_not_found;
  logic                  w_not_found_n;
  logic                  r_aborted;
  logic                  w_aborted_n;
  logic                  r_valid_lat;
  logic                  w_valid_lat_n;
  logic [NUM_PHASES-1:0] w_phase_start;
  logic                  w_load;
  logic                  w_step;
  logic                  w_count;
  logic                  w_first_oob;
  logic                  w_last_key;

  rc4_key_stepper #(
    .KEY_W   (KEY_W),
    .MIN_KEY (MIN_KEY),
    .MAX_KEY (MAX_KEY),
    .OFFSET  (OFFSET),
    .STRIDE  (STRIDE)
  ) u_stepper (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_load),
    .step       (w_step),
    .count      (w_count),
    .first_oob  (w_first_oob),
    .last_key   (w_last_key),
    .key        (key),
    .keys_tried (keys_tried)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_phase_sel <= PH_SETUP;
      r_found     <= 1'b0;
      r_not_found <= 1'b0;
      r_aborted   <= 1'b0;
      r_valid_lat <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_phase_sel <= w_phase_sel_n;
      r_found     <= w_found_n;
      r_not_found <= w_not_found_n;
      r_aborted   <= w_aborted_n;
      r_valid_lat <= w_valid_lat_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_phase_sel_n = r_phase_sel;
    w_found_n     = r_found;
    w_not_found_n = r_not_found;
    w_aborted_n   = r_aborted;
    w_valid_lat_n = r_valid_lat;
    w_phase_start = '0;
    w_load        = 1'b0;
    w_step        = 1'b0;
    w_count       = 1'b0;

    unique case (r_state)
      // Idle states: halt is deliberately not looked at here, so a
      // same-cycle start+halt starts the search and the halt (if still
      // high) is taken from LOAD on the following cycle.
      IDLE, DONE: begin
        if (start) begin
          w_state_n     = LOAD;
          w_found_n     = 1'b0;
          w_not_found_n = 1'b0;
          w_aborted_n   = 1'b0;
          w_load        = 1'b1;
        end
`ifdef RC4_KEY_RESUME_EN
        else if (resume && (r_state == DONE) && r_found) begin
          // Continue past the winning key using the same end-of-range
          // test as EVAL; keys_tried is left untouched.
          w_found_n = 1'b0;
          if (w_last_key) begin
            w_not_found_n = 1'b1;
          end else begin
            w_state_n = NEXT;
          end
        end
`endif
      end

      default: begin
        if (halt) begin
          // Abort wins over any progress this cycle; phase_start stays 0
          // and the stepper receives no load/step/count.
          w_state_n   = DONE;
          w_aborted_n = 1'b1;
        end else begin
          case (r_state)
            LOAD: begin
              if (w_first_oob) begin
                w_state_n     = DONE;
                w_not_found_n = 1'b1;
              end else begin
                w_phase_sel_n = PH_SETUP;
                w_state_n     = START_PH;
              end
            end

            START_PH: begin
              w_phase_start = phase_onehot(r_phase_sel);
              w_state_n     = WAIT_PH;
            end

            WAIT_PH: begin
              // Only the finish bit of the active phase is honoured.
              if (eng.phase_finish[r_phase_sel]) begin
                if (r_phase_sel == PH_CHECK) begin
                  w_valid_lat_n = eng.valid;
                  w_state_n     = EVAL;
                end else begin
                  w_phase_sel_n = r_phase_sel + 2'd1;
                  w_state_n     = START_PH;
                end
              end
            end

            EVAL: begin
              w_count = 1'b1;
              if (r_valid_lat) begin
                w_found_n = 1'b1;
                w_state_n = DONE;
              end else if (w_last_key) begin
                w_not_found_n = 1'b1;
                w_state_n     = DONE;
              end else begin
                w_state_n = NEXT;
              end
            end

            NEXT: begin
              w_step        = 1'b1;
              w_phase_sel_n = PH_SETUP;
              w_state_n     = START_PH;
            end

            default: begin
              w_state_n = r_state;
            end
          endcase
        end
      end
    endcase
  end

  assign eng.phase_start = w_phase_start;
  assign eng.phase_sel   = r_phase_sel;
  assign busy            = (r_state != IDLE) && (r_state != DONE);
  assign found           = r_found;
  assign not_found       = r_not_found;
  assign aborted         = r_aborted;

endmodule
`default_nettype wire
